// File: rtl/nanov_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nanov_pkg
// Description : Shared definitions for the nanov bit-serial register
//               sequencer: register-index and bit-counter widths, the
//               operand width, and the sequencer state encoding.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package nanov_pkg;

    localparam int REG_IDX_W = 4;
    localparam int XLEN      = 32;
    localparam int BIT_CNT_W = 5;

    // Position of the final serial bit of an operation.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_RESUME = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/nanov_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : nanov_bit_counter
// Description : Serial bit-position counter. Counts modulo 2**BIT_CNT_W while
//               enabled; synchronous clear; flags the final bit position.
// Ports       : clk   - clock
//               rstn  - synchronous active-low reset
//               clr   - synchronous clear to 0 (wins over en)
//               en    - advance by one this cycle
//               cnt   - current bit position
//               wrap  - cnt is at the final bit; next enabled step wraps to 0
// Revision    : 1.0  initial release
// ============================================================================
module nanov_bit_counter
    import nanov_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 en,
    output logic [BIT_CNT_W-1:0] cnt,
    output logic                 wrap
);

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            cnt <= '0;
        end else if (en) begin
            // Natural overflow provides the 31 -> 0 wrap.
            cnt <= cnt + BIT_CNT_W'(1);
        end
    end

    assign wrap = (cnt == LAST_BIT);

endmodule
`default_nettype wire

// File: rtl/nanov_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nanov_reg_sequencer
// Description : Sequences 32-step bit-serial register operations. Latches the
//               operand/destination indices on acceptance, walks the bit
//               position, pauses on stall (with a one-cycle resume bubble),
//               and generates register-file write / forward controls.
//               Operations may be chained back-to-back on the final bit.
// Ports       : clk, rstn            - clock, synchronous active-low reset
//               start                - request a new operation
//               rs1_in/rs2_in/rd_in  - indices of the requested operation
//               wb_in                - requested operation writes rd
//               stall                - no bit step this cycle
//               ready                - start is accepted this cycle
//               rs1/rs2/rd           - latched indices of current operation
//               next_rs1/next_rs2    - read indices one cycle ahead
//               bit_cnt              - current bit position
//               wr_en/wr_next_en     - register-file write enables
//               read_through         - forward outgoing result to next op
//               done                 - final-bit pulse
// Revision    : 1.0  initial release
// ============================================================================
module nanov_reg_sequencer
    import nanov_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [REG_IDX_W-1:0] rs1_in,
    input  logic [REG_IDX_W-1:0] rs2_in,
    input  logic [REG_IDX_W-1:0] rd_in,
    input  logic                 wb_in,
    input  logic                 stall,
    output logic                 ready,
    output logic [REG_IDX_W-1:0] rs1,
    output logic [REG_IDX_W-1:0] rs2,
    output logic [REG_IDX_W-1:0] rd,
    output logic [REG_IDX_W-1:0] next_rs1,
    output logic [REG_IDX_W-1:0] next_rs2,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 wr_en,
    output logic                 wr_next_en,
    output logic                 read_through,
    output logic                 done
);

    seq_state_t state;
    logic       wb;
    logic       cnt_last;
    logic       step;
    logic       boundary;
    logic       accept;
    logic       wr_target;

    // ------------------------------------------------------------------
    // Decode from registered state (plus stall/start where required)
    // ------------------------------------------------------------------
    always_comb begin
        step      = (state == ST_RUN) && !stall;
        boundary  = step && cnt_last;
        ready     = (state == ST_IDLE) || boundary;
        accept    = ready && start;
        // Register 0 is hard-wired: never written, never forwarded.
        wr_target = wb && (rd != '0);
        // rstn gating ensures no partial write escapes in a reset cycle.
        wr_en        = rstn && step && wr_target;
        wr_next_en   = wr_en && !cnt_last;
        read_through = rstn && boundary && start && wr_target;
        done         = rstn && boundary;
        // The register file reads one cycle ahead, so an accepted start
        // must steer the read port to the incoming indices immediately.
        next_rs1 = accept ? rs1_in : rs1;
        next_rs2 = accept ? rs2_in : rs2;
    end

    // ------------------------------------------------------------------
    // Bit position counter
    // ------------------------------------------------------------------
    nanov_bit_counter u_bit_counter (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state == ST_IDLE),
        .en   (step),
        .cnt  (bit_cnt),
        .wrap (cnt_last)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM and operation field latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
            rs1   <= '0;
            rs2   <= '0;
            rd    <= '0;
            wb    <= 1'b0;
        end else begin
            if (accept) begin
                rs1 <= rs1_in;
                rs2 <= rs2_in;
                rd  <= rd_in;
                wb  <= wb_in;
            end
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (stall)
                        state <= ST_PAUSE;
                    else if (cnt_last && !start)
                        state <= ST_IDLE;
                    // cnt_last with start: stay in RUN, back-to-back.
                end
                ST_PAUSE: begin
                    if (!stall) state <= ST_RESUME;
                end
                ST_RESUME: begin
                    // One bubble cycle before stepping resumes.
                    state <= stall ? ST_PAUSE : ST_RUN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nanov_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nanov_reg_sequencer
// Description : Directed self-checking bench for nanov_reg_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nanov_reg_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rs1_in = '0;
    logic [3:0] rs2_in = '0;
    logic [3:0] rd_in = '0;
    logic       wb_in = 1'b0;
    logic       stall = 1'b0;
    logic       ready;
    logic [3:0] rs1, rs2, rd, next_rs1, next_rs2;
    logic [4:0] bit_cnt;
    logic       wr_en, wr_next_en, read_through, done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    nanov_reg_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .rs1_in       (rs1_in),
        .rs2_in       (rs2_in),
        .rd_in        (rd_in),
        .wb_in        (wb_in),
        .stall        (stall),
        .ready        (ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .next_rs1     (next_rs1),
        .next_rs2     (next_rs2),
        .bit_cnt      (bit_cnt),
        .wr_en        (wr_en),
        .wr_next_en   (wr_next_en),
        .read_through (read_through),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 2 units later, well before the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic w, input logic st);
        start = s; rs1_in = a; rs2_in = b; rd_in = d; wb_in = w; stall = st;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        rstn = 1'b1;
        #2;
        total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (bit_cnt !== 5'd0) $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); else pass_cnt++;
        total_cnt++; if ({rs1, rs2, rd} !== 12'h000) $display("FAIL reset_fields: got %h want 000", {rs1, rs2, rd}); else pass_cnt++;
        total_cnt++; if ({next_rs1, next_rs2} !== 8'h00) $display("FAIL reset_next: got %h want 00", {next_rs1, next_rs2}); else pass_cnt++;
        total_cnt++; if ({wr_en, wr_next_en, read_through, done} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000", {wr_en, wr_next_en, read_through, done}); else pass_cnt++;
        cyc();
    endtask

    task automatic test_single_op();
        drive(1, 3, 4, 5, 1, 0);
        #2;
        total_cnt++; if (ready !== 1'b1) $display("FAIL single_accept_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if ({next_rs1, next_rs2} !== 8'h34) $display("FAIL single_next_fwd: got %h want 34", {next_rs1, next_rs2}); else pass_cnt++;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL single_idle_wr: got %b want 0", wr_en); else pass_cnt++;
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            #2;
            total_cnt++; if (bit_cnt !== 5'(i)) $display("FAIL single_bit_cnt: got %0d want %0d", bit_cnt, i); else pass_cnt++;
            total_cnt++; if (wr_en !== 1'b1) $display("FAIL single_wr_en bit %0d: got %b want 1", i, wr_en); else pass_cnt++;
            total_cnt++; if (wr_next_en !== (i != 31)) $display("FAIL single_wr_next_en bit %0d: got %b want %b", i, wr_next_en, (i != 31)); else pass_cnt++;
            total_cnt++; if (done !== (i == 31)) $display("FAIL single_done bit %0d: got %b want %b", i, done, (i == 31)); else pass_cnt++;
            total_cnt++; if (ready !== (i == 31)) $display("FAIL single_ready bit %0d: got %b want %b", i, ready, (i == 31)); else pass_cnt++;
            total_cnt++; if ({rs1, rs2, rd} !== 12'h345) $display("FAIL single_fields: got %h want 345", {rs1, rs2, rd}); else pass_cnt++;
            cyc();
        end
        #2;
        total_cnt++; if (ready !== 1'b1) $display("FAIL single_idle_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL single_idle_wr_en: got %b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (bit_cnt !== 5'd0) $display("FAIL single_idle_bit_cnt: got %0d want 0", bit_cnt); else pass_cnt++;
        total_cnt++; if (next_rs1 !== 4'd3) $display("FAIL single_idle_next_rs1: got %0d want 3", next_rs1); else pass_cnt++;
        cyc();
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 2, 5, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) begin
            #2;
            total_cnt++; if (read_through !== 1'b0) $display("FAIL b2b_rt_early bit %0d: got %b want 0", i, read_through); else pass_cnt++;
            cyc();
        end
        drive(1, 5, 6, 7, 0, 0);
        #2;
        total_cnt++; if (bit_cnt !== 5'd31) $display("FAIL b2b_boundary_bit: got %0d want 31", bit_cnt); else pass_cnt++;
        total_cnt++; if (read_through !== 1'b1) $display("FAIL b2b_read_through: got %b want 1", read_through); else pass_cnt++;
        total_cnt++; if ({next_rs1, next_rs2} !== 8'h56) $display("FAIL b2b_next: got %h want 56", {next_rs1, next_rs2}); else pass_cnt++;
        total_cnt++; if ({done, ready, wr_en, wr_next_en} !== 4'b1110)
            $display("FAIL b2b_boundary_ctrl: got %b want 1110", {done, ready, wr_en, wr_next_en}); else pass_cnt++;
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        total_cnt++; if (bit_cnt !== 5'd0) $display("FAIL b2b_b_bit0: got %0d want 0", bit_cnt); else pass_cnt++;
        total_cnt++; if ({rs1, rs2, rd} !== 12'h567) $display("FAIL b2b_b_fields: got %h want 567", {rs1, rs2, rd}); else pass_cnt++;
        total_cnt++; if ({wr_en, read_through, ready} !== 3'b000) $display("FAIL b2b_b_ctrl: got %b want 000", {wr_en, read_through, ready}); else pass_cnt++;
        cyc();
        for (int i = 1; i < 32; i++) begin
            #2;
            total_cnt++; if (wr_en !== 1'b0) $display("FAIL b2b_b_nowb bit %0d: got %b want 0", i, wr_en); else pass_cnt++;
            cyc();
        end
        #2;
        total_cnt++; if ({ready, bit_cnt} !== {1'b1, 5'd0}) $display("FAIL b2b_idle: got %b/%0d want 1/0", ready, bit_cnt); else pass_cnt++;
        cyc();
    endtask

    task automatic test_stall();
        int  steps;
        logic done_seen;
        steps = 0;
        done_seen = 1'b0;
        drive(1, 7, 8, 9, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            #2;
            if (wr_en) steps++;
            cyc();
        end
        // RUN at bit 10 with stall raised: no step.
        drive(0, 0, 0, 0, 0, 1);
        #2;
        total_cnt++; if (bit_cnt !== 5'd10) $display("FAIL stall_run_bit: got %0d want 10", bit_cnt); else pass_cnt++;
        total_cnt++; if ({wr_en, done} !== 2'b00) $display("FAIL stall_run_ctrl: got %b want 00", {wr_en, done}); else pass_cnt++;
        cyc();
        // Two PAUSE cycles, start held high with other indices: ignored.
        for (int i = 0; i < 2; i++) begin
            drive(1, 15, 14, 13, 1, 1);
            #2;
            total_cnt++; if (ready !== 1'b0) $display("FAIL pause_ready: got %b want 0", ready); else pass_cnt++;
            total_cnt++; if ({wr_en, bit_cnt} !== {1'b0, 5'd10}) $display("FAIL pause_hold: got %b/%0d want 0/10", wr_en, bit_cnt); else pass_cnt++;
            total_cnt++; if ({next_rs1, next_rs2} !== 8'h78) $display("FAIL pause_next: got %h want 78", {next_rs1, next_rs2}); else pass_cnt++;
            cyc();
        end
        // Stall released in PAUSE -> RESUME next.
        drive(0, 0, 0, 0, 0, 0);
        #2;
        total_cnt++; if ({wr_en, bit_cnt} !== {1'b0, 5'd10}) $display("FAIL pause_exit: got %b/%0d want 0/10", wr_en, bit_cnt); else pass_cnt++;
        cyc();
        // RESUME bubble, start still ignored.
        drive(1, 15, 14, 13, 1, 0);
        #2;
        total_cnt++; if ({ready, wr_en, bit_cnt} !== {1'b0, 1'b0, 5'd10})
            $display("FAIL resume_bubble: got %b/%b/%0d want 0/0/10", ready, wr_en, bit_cnt); else pass_cnt++;
        cyc();
        // First RUN cycle after RESUME performs bit 10.
        drive(0, 0, 0, 0, 0, 0);
        #2;
        total_cnt++; if ({wr_en, bit_cnt} !== {1'b1, 5'd10}) $display("FAIL resume_run: got %b/%0d want 1/10", wr_en, bit_cnt); else pass_cnt++;
        total_cnt++; if ({rs1, rs2, rd} !== 12'h789) $display("FAIL stall_fields: got %h want 789", {rs1, rs2, rd}); else pass_cnt++;
        if (wr_en) steps++;
        cyc();
        #2;
        total_cnt++; if (bit_cnt !== 5'd11) $display("FAIL stall_after_bit: got %0d want 11", bit_cnt); else pass_cnt++;
        for (int k = 0; k < 40; k++) begin
            if (wr_en) steps++;
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            cyc();
            #2;
        end
        total_cnt++; if (done_seen !== 1'b1) $display("FAIL stall_done_timeout: got %b want 1", done_seen); else pass_cnt++;
        total_cnt++; if (steps !== 32) $display("FAIL stall_total_steps: got %0d want 32", steps); else pass_cnt++;
        total_cnt++; if (bit_cnt !== 5'd31) $display("FAIL stall_done_bit: got %0d want 31", bit_cnt); else pass_cnt++;
        cyc();
        #2;
        total_cnt++; if (ready !== 1'b1) $display("FAIL stall_idle_ready: got %b want 1", ready); else pass_cnt++;
        cyc();
    endtask

    task automatic test_rd_zero();
        int wr_seen;
        int done_cnt;
        wr_seen = 0;
        done_cnt = 0;
        drive(1, 1, 2, 0, 1, 0);
        cyc();
        for (int i = 0; i < 32; i++) begin
            if (i == 31) drive(1, 3, 4, 0, 1, 0);
            else         drive(0, 0, 0, 0, 0, 0);
            #2;
            if (wr_en || wr_next_en || read_through) wr_seen++;
            if (done) done_cnt++;
            if (i == 31) begin
                total_cnt++; if ({done, ready, read_through} !== 3'b110)
                    $display("FAIL rd0_boundary: got %b want 110", {done, ready, read_through}); else pass_cnt++;
            end
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            #2;
            if (wr_en || wr_next_en || read_through) wr_seen++;
            if (done) done_cnt++;
            if (i == 31) begin
                total_cnt++; if (done !== 1'b1) $display("FAIL rd0_b_done: got %b want 1", done); else pass_cnt++;
            end
            cyc();
        end
        #2;
        total_cnt++; if (wr_seen !== 0) $display("FAIL rd0_writes: got %0d want 0", wr_seen); else pass_cnt++;
        total_cnt++; if (done_cnt !== 2) $display("FAIL rd0_done_count: got %0d want 2", done_cnt); else pass_cnt++;
        total_cnt++; if (ready !== 1'b1) $display("FAIL rd0_idle: got %b want 1", ready); else pass_cnt++;
        cyc();
    endtask

    task automatic test_reset_mid();
        int wcnt;
        wcnt = 0;
        drive(1, 3, 4, 5, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) cyc();
        #2;
        total_cnt++; if ({wr_en, bit_cnt} !== {1'b1, 5'd17}) $display("FAIL rstmid_pre: got %b/%0d want 1/17", wr_en, bit_cnt); else pass_cnt++;
        rstn = 1'b0;
        #1;
        total_cnt++; if ({wr_en, wr_next_en, done} !== 3'b000) $display("FAIL rstmid_nowrite: got %b want 000", {wr_en, wr_next_en, done}); else pass_cnt++;
        cyc();
        rstn = 1'b1;
        #2;
        total_cnt++; if ({ready, bit_cnt} !== {1'b1, 5'd0}) $display("FAIL rstmid_state: got %b/%0d want 1/0", ready, bit_cnt); else pass_cnt++;
        total_cnt++; if ({rs1, rs2, rd, next_rs1, next_rs2} !== 20'h00000)
            $display("FAIL rstmid_fields: got %h want 00000", {rs1, rs2, rd, next_rs1, next_rs2}); else pass_cnt++;
        total_cnt++; if ({wr_en, wr_next_en, read_through, done} !== 4'b0000)
            $display("FAIL rstmid_ctrl: got %b want 0000", {wr_en, wr_next_en, read_through, done}); else pass_cnt++;
        cyc();
        drive(1, 3, 4, 6, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            #2;
            if (wr_en) wcnt++;
            if (i == 31) begin
                total_cnt++; if ({done, bit_cnt} !== {1'b1, 5'd31}) $display("FAIL rstmid_new_done: got %b/%0d want 1/31", done, bit_cnt); else pass_cnt++;
            end
            cyc();
        end
        #2;
        total_cnt++; if (wcnt !== 32) $display("FAIL rstmid_new_steps: got %0d want 32", wcnt); else pass_cnt++;
        total_cnt++; if ({ready, rd} !== {1'b1, 4'd6}) $display("FAIL rstmid_new_idle: got %b/%0d want 1/6", ready, rd); else pass_cnt++;
        cyc();
    endtask

    initial begin
        #1;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_stall();
        test_rd_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
